// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/align stage.
// Halfword buffer geometry, fetch FSM encoding, RV32C length test.
package fetch_pkg;

   localparam int HW_W   = 16;
   localparam int BUF_HW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   function automatic logic is_compressed(input logic [HW_W-1:0] h);
      return h[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_hw_buf.sv
// Four-halfword shift buffer: pop 0-2 from the head, then push 0-2
// at the tail in the same cycle; flush empties it.
module fetch_hw_buf
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [1:0]        pop_n,
   input  logic [1:0]        push_n,
   input  logic [2*HW_W-1:0] push_data,
   output logic [HW_W-1:0]   h0,
   output logic [HW_W-1:0]   h1,
   output logic [2:0]        count
);

   logic [HW_W-1:0] hw_q [BUF_HW];
   logic [HW_W-1:0] hw_d [BUF_HW];
   logic [2:0]      base;
   logic [2:0]      cnt_d;

   always_comb begin
      hw_d = hw_q;
      base = count - {1'b0, pop_n};
      for (int i = 0; i < BUF_HW; i++) begin
         if (i + int'(pop_n) < BUF_HW)
            hw_d[i] = hw_q[i + int'(pop_n)];
         else
            hw_d[i] = '0;
      end
      // Tail slots are free: the fetcher only requests when count <= 2.
      if (push_n != 2'd0 && base < 3'd4)
         hw_d[base[1:0]] = push_data[HW_W-1:0];
      if (push_n == 2'd2 && base < 3'd3)
         hw_d[base[1:0] + 2'd1] = push_data[2*HW_W-1:HW_W];
      cnt_d = flush ? 3'd0 : base + {1'b0, push_n};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 3'd0;
         for (int i = 0; i < BUF_HW; i++)
            hw_q[i] <= '0;
      end else begin
         count <= cnt_d;
         hw_q  <= hw_d;
      end
   end

   assign h0 = hw_q[0];
   assign h1 = hw_q[1];

endmodule

// File: rtl/fetch_align.sv
// Fetch/align stage: word-aligned memory reads, halfword buffering,
// one 16- or 32-bit instruction per handshake, redirect handling.
module fetch_align
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_compressed_o
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  fa_q;
   logic         skip_q;

   logic [HW_W-1:0] h0;
   logic [HW_W-1:0] h1;
   logic [2:0]      count;
   logic            comp;
   logic            pop_fire;
   logic            accept;
   logic [1:0]      pop_n;
   logic [1:0]      push_n;
   logic [31:0]     push_data;

   assign comp = is_compressed(h0);

   assign inst_valid_o      = (count != 3'd0 && comp) || count >= 3'd2;
   assign inst_compressed_o = (count != 3'd0) && comp;
   assign inst_o            = comp ? {16'h0, h0} : {h1, h0};
   assign inst_pc_o         = pc_q;

   // Gated by reset so every handshake output is low while held.
   assign mem_req_o  = state_q == IDLE && count <= 3'd2 && !rst_i;
   assign mem_addr_o = fa_q;

   assign pop_fire = inst_valid_o && inst_ready_i && !redirect_i;
   assign accept   = state_q == WAIT && mem_rvalid_i && !redirect_i;
   assign pop_n    = pop_fire ? (comp ? 2'd1 : 2'd2) : 2'd0;
   assign push_n   = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
   assign push_data = skip_q ? {16'h0, mem_rdata_i[31:16]}
                             : mem_rdata_i;

   fetch_hw_buf u_buf (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (redirect_i),
      .pop_n     (pop_n),
      .push_n    (push_n),
      .push_data (push_data),
      .h0        (h0),
      .h1        (h1),
      .count     (count)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         fa_q    <= RESET_PC & ~32'h3;
         skip_q  <= RESET_PC[1];
      end else begin
         if (pop_fire)
            pc_q <= pc_q + (comp ? 32'd2 : 32'd4);
         if (redirect_i) begin
            pc_q   <= {redirect_pc_i[31:1], 1'b0};
            fa_q   <= redirect_pc_i & ~32'h3;
            skip_q <= redirect_pc_i[1];
         end else begin
            if (mem_req_o)
               fa_q <= fa_q + 32'd4;
            if (accept)
               skip_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (mem_req_o)
                  state_q <= redirect_i ? DROP : WAIT;
            end
            WAIT: begin
               if (mem_rvalid_i)
                  state_q <= IDLE;
               else if (redirect_i)
                  state_q <= DROP;
            end
            DROP: begin
               // A response in the same cycle as a redirect still retires the read.
               if (mem_rvalid_i)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
